// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: entry layout, instruction classes and
// exception codes.
package rob_pkg;

  // Storage width of the data/address fields held in each entry.
  localparam int RV_XLEN = 32;

  typedef enum logic [2:0] {
    IT_ALU    = 3'd0,
    IT_MUL    = 3'd1,
    IT_LOAD   = 3'd2,
    IT_STORE  = 3'd3,
    IT_BRANCH = 3'd4
  } instr_type_e;

  localparam logic [2:0] EXC_NONE    = 3'd0;
  localparam logic [2:0] EXC_ITLB    = 3'd1;
  localparam logic [2:0] EXC_DTLB    = 3'd2;
  localparam logic [2:0] EXC_ILLEGAL = 3'd3;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] addr_miss;
    logic [RV_XLEN-1:0] value;
    logic [4:0]         rd;
    logic               valid;
    logic               complete;
    logic [2:0]         exception;
    instr_type_e        instr_type;
  } rob_entry_t;

  // True when an exception code reports a fault.
  function automatic logic exc_pending(input logic [2:0] code);
    return code != EXC_NONE;
  endfunction

endpackage

// File: rtl/rob_multiport_if.sv
// Bundle of allocate / complete / commit / status signals of the reorder
// buffer. The ROB uses the slave view; decode, execute and the commit
// consumer together form the master view.
interface rob_multiport_if #(
  parameter int DEPTH   = 16,
  parameter int NUM_CPL = 2,
  parameter int XLEN    = 32
);
  localparam int IDX_W = $clog2(DEPTH);

  logic                     alloc_valid;
  logic [XLEN-1:0]          alloc_pc;
  logic [XLEN-1:0]          alloc_addr_miss;
  logic [4:0]               alloc_rd;
  logic [2:0]               alloc_instr_type;
  logic                     stall;
  logic                     alloc_ready;
  logic [IDX_W-1:0]         alloc_idx;

  logic [NUM_CPL-1:0]       cpl_valid;
  logic [NUM_CPL*IDX_W-1:0] cpl_idx;
  logic [NUM_CPL*XLEN-1:0]  cpl_value;
  logic [NUM_CPL*3-1:0]     cpl_exception;

  logic                     commit_valid;
  logic                     commit_ready;
  logic [IDX_W-1:0]         commit_idx;
  logic [XLEN-1:0]          commit_pc;
  logic [XLEN-1:0]          commit_addr_miss;
  logic [XLEN-1:0]          commit_value;
  logic [4:0]               commit_rd;
  logic [2:0]               commit_exception;
  logic [2:0]               commit_instr_type;

  logic                     flush;
  logic                     full;
  logic                     empty;
  logic [IDX_W:0]           count;

  modport master (
    output alloc_valid, alloc_pc, alloc_addr_miss, alloc_rd, alloc_instr_type, stall,
    input  alloc_ready, alloc_idx,
    output cpl_valid, cpl_idx, cpl_value, cpl_exception,
    input  commit_valid, commit_idx, commit_pc, commit_addr_miss, commit_value,
    input  commit_rd, commit_exception, commit_instr_type,
    output commit_ready,
    input  flush, full, empty, count
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_addr_miss, alloc_rd, alloc_instr_type, stall,
    output alloc_ready, alloc_idx,
    input  cpl_valid, cpl_idx, cpl_value, cpl_exception,
    output commit_valid, commit_idx, commit_pc, commit_addr_miss, commit_value,
    output commit_rd, commit_exception, commit_instr_type,
    input  commit_ready,
    output flush, full, empty, count
  );

endinterface

// File: rtl/rob_multiport_chk.sv
// Simulation checks for the reorder buffer completion ports.
module rob_multiport_chk #(
  parameter int NUM_CPL = 2,
  parameter int IDX_W   = 4
) (
  input logic                     clk,
  input logic                     reset,
  input logic [NUM_CPL-1:0]       cpl_valid,
  input logic [NUM_CPL*IDX_W-1:0] cpl_idx
);

  logic collision_s;

  // Detect two active completion ports aimed at the same entry.
  always_comb begin
    collision_s = 1'b0;
    for (int p = 0; p < NUM_CPL; p++) begin
      for (int q = p + 1; q < NUM_CPL; q++) begin
        if (cpl_valid[p] && cpl_valid[q] &&
            (cpl_idx[p*IDX_W +: IDX_W] == cpl_idx[q*IDX_W +: IDX_W])) begin
          collision_s = 1'b1;
        end else begin
          collision_s = collision_s;
        end
      end
    end
  end

  // Flag same-index completions; the highest-numbered port is the one kept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cpl_collision: assert (!collision_s)
        else $warning("rob_multiport: completion ports collided on one entry, highest port kept");
    end
  end

endmodule

// File: rtl/rob_ptr_wrap.sv
// Modulo-DEPTH pointer increment; DEPTH need not be a power of two.
module rob_ptr_wrap #(
  parameter  int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] ptr_nxt
);

  // Advance by one, wrapping the last entry back to zero.
  always_comb begin
    if (ptr == IDX_W'(DEPTH - 1)) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = ptr + IDX_W'(1);
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// In-order-commit reorder buffer with NUM_CPL completion ports. Decode
// allocates at the tail, completions mark entries out of order, and the head
// retires through a valid/ready handshake. An excepting head is reported once
// and then the whole buffer is flushed.
module rob_multiport
  import rob_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int NUM_CPL = 2,
  parameter int XLEN    = RV_XLEN
) (
  input logic             clk,
  input logic             reset,
  rob_multiport_if.slave  rob
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [0:0] ST_RUN         = 1'b0;
  localparam logic [0:0] ST_FLUSH_PULSE = 1'b1;

  rob_entry_t       entries_r [DEPTH];
  logic [IDX_W-1:0] head_r;
  logic [IDX_W-1:0] tail_r;
  logic [IDX_W:0]   count_r;
  logic [0:0]       state_r;

  logic [IDX_W-1:0] head_nxt_s;
  logic [IDX_W-1:0] tail_nxt_s;
  rob_entry_t       head_s;
  logic             commit_valid_s;
  logic             commit_fire_s;
  logic             flush_now_s;
  logic             alloc_fire_s;
  logic             alloc_ready_s;
  logic             full_s;
  logic             empty_s;
  logic [NUM_CPL-1:0] cpl_hit_s;
  logic [IDX_W-1:0] cpl_idx_s [NUM_CPL];

  rob_ptr_wrap #(.DEPTH(DEPTH)) u_head_wrap (.ptr(head_r), .ptr_nxt(head_nxt_s));
  rob_ptr_wrap #(.DEPTH(DEPTH)) u_tail_wrap (.ptr(tail_r), .ptr_nxt(tail_nxt_s));

  rob_multiport_chk #(.NUM_CPL(NUM_CPL), .IDX_W(IDX_W)) u_chk (
    .clk       (clk),
    .reset     (reset),
    .cpl_valid (rob.cpl_valid),
    .cpl_idx   (rob.cpl_idx)
  );

  // Head view, occupancy flags and the handshake decisions for this cycle.
  // Allocation readiness uses the registered count, so a commit freeing the
  // last slot cannot be paired with an allocation in the same cycle.
  always_comb begin
    head_s         = entries_r[head_r];
    commit_valid_s = head_s.valid && head_s.complete;
    full_s         = (count_r == (IDX_W + 1)'(DEPTH));
    empty_s        = (count_r == '0);
    alloc_ready_s  = !full_s && !rob.stall &&
                     !(commit_valid_s && exc_pending(head_s.exception));
    commit_fire_s  = commit_valid_s && rob.commit_ready;
    flush_now_s    = commit_fire_s && exc_pending(head_s.exception);
    alloc_fire_s   = rob.alloc_valid && alloc_ready_s;
  end

  // A completion only lands on a live entry that has not completed yet.
  always_comb begin
    for (int p = 0; p < NUM_CPL; p++) begin
      cpl_idx_s[p] = rob.cpl_idx[p*IDX_W +: IDX_W];
      if (rob.cpl_valid[p] && (int'(cpl_idx_s[p]) < DEPTH)) begin
        cpl_hit_s[p] = entries_r[cpl_idx_s[p]].valid && !entries_r[cpl_idx_s[p]].complete;
      end else begin
        cpl_hit_s[p] = 1'b0;
      end
    end
  end

  // Entry storage: flush clears everything, otherwise merge completions
  // (later ports overwrite earlier ones), retire the head and fill the tail.
  always_ff @(posedge clk) begin
    if (reset || flush_now_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_CPL; p++) begin
        if (cpl_hit_s[p]) begin
          entries_r[cpl_idx_s[p]].value     <= RV_XLEN'(rob.cpl_value[p*XLEN +: XLEN]);
          entries_r[cpl_idx_s[p]].exception <= rob.cpl_exception[p*3 +: 3];
          entries_r[cpl_idx_s[p]].complete  <= 1'b1;
        end
      end
      if (commit_fire_s) begin
        entries_r[head_r].valid    <= 1'b0;
        entries_r[head_r].complete <= 1'b0;
      end
      if (alloc_fire_s) begin
        entries_r[tail_r] <= '{
          pc:         RV_XLEN'(rob.alloc_pc),
          addr_miss:  RV_XLEN'(rob.alloc_addr_miss),
          value:      '0,
          rd:         rob.alloc_rd,
          valid:      1'b1,
          complete:   1'b0,
          exception:  EXC_NONE,
          instr_type: instr_type_e'(rob.alloc_instr_type)
        };
      end
    end
  end

  // Head/tail pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset || flush_now_s) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (commit_fire_s) begin
        head_r <= head_nxt_s;
      end
      if (alloc_fire_s) begin
        tail_r <= tail_nxt_s;
      end
      case ({alloc_fire_s, commit_fire_s})
        2'b10:   count_r <= count_r + (IDX_W + 1)'(1);
        2'b01:   count_r <= count_r - (IDX_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Flush FSM: one FLUSH_PULSE cycle after an exception retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN:         state_r <= flush_now_s ? ST_FLUSH_PULSE : ST_RUN;
        ST_FLUSH_PULSE: state_r <= ST_RUN;
        default:        state_r <= ST_RUN;
      endcase
    end
  end

  // Drive the interface; commit data reads as zero unless the head can retire.
  always_comb begin
    rob.alloc_ready       = alloc_ready_s;
    rob.alloc_idx         = tail_r;
    rob.commit_valid      = commit_valid_s;
    rob.commit_idx        = commit_valid_s ? head_r : '0;
    rob.commit_pc         = commit_valid_s ? XLEN'(head_s.pc) : '0;
    rob.commit_addr_miss  = commit_valid_s ? XLEN'(head_s.addr_miss) : '0;
    rob.commit_value      = commit_valid_s ? XLEN'(head_s.value) : '0;
    rob.commit_rd         = commit_valid_s ? head_s.rd : 5'd0;
    rob.commit_exception  = commit_valid_s ? head_s.exception : 3'd0;
    rob.commit_instr_type = commit_valid_s ? head_s.instr_type : 3'd0;
    rob.flush             = (state_r == ST_FLUSH_PULSE);
    rob.full              = full_s;
    rob.empty             = empty_s;
    rob.count             = count_r;
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Self-checking bench for rob_multiport (DEPTH=10): directed scenarios with
// literal expectations, then randomized traffic against a queue-based model.
module tb_rob_multiport;
  localparam int DEPTH   = 10;
  localparam int NUM_CPL = 2;
  localparam int XLEN    = 32;
  localparam int IDX_W   = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rob_multiport_if #(.DEPTH(DEPTH), .NUM_CPL(NUM_CPL), .XLEN(XLEN)) rob_bus ();

  rob_multiport #(.DEPTH(DEPTH), .NUM_CPL(NUM_CPL), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .rob   (rob_bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Model: live instructions in program order, each with its slot index.
  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic [31:0] miss;
    logic [31:0] value;
    logic [4:0]  rd;
    logic [2:0]  itype;
    logic [2:0]  exc;
    bit          done;
  } ment_t;

  ment_t mq[$];
  int    m_tail  = 0;
  bit    m_flush = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against what the model says it must be now.
  task automatic compare_model();
    ment_t h;
    bit    cv;
    h  = '{default: 0};
    cv = 1'b0;
    if (mq.size() > 0) begin
      h  = mq[0];
      cv = mq[0].done;
    end
    chk("count", 64'(rob_bus.count), 64'(mq.size()));
    chk("empty", 64'(rob_bus.empty), 64'(mq.size() == 0));
    chk("full", 64'(rob_bus.full), 64'(mq.size() == DEPTH));
    chk("alloc_idx", 64'(rob_bus.alloc_idx), 64'(m_tail));
    chk("alloc_ready", 64'(rob_bus.alloc_ready),
        64'((mq.size() < DEPTH) && !rob_bus.stall && !(cv && h.exc != 3'd0)));
    chk("flush", 64'(rob_bus.flush), 64'(m_flush));
    chk("commit_valid", 64'(rob_bus.commit_valid), 64'(cv));
    chk("commit_idx", 64'(rob_bus.commit_idx), cv ? 64'(h.idx) : 64'd0);
    chk("commit_pc", 64'(rob_bus.commit_pc), cv ? 64'(h.pc) : 64'd0);
    chk("commit_miss", 64'(rob_bus.commit_addr_miss), cv ? 64'(h.miss) : 64'd0);
    chk("commit_value", 64'(rob_bus.commit_value), cv ? 64'(h.value) : 64'd0);
    chk("commit_rd", 64'(rob_bus.commit_rd), cv ? 64'(h.rd) : 64'd0);
    chk("commit_exc", 64'(rob_bus.commit_exception), cv ? 64'(h.exc) : 64'd0);
    chk("commit_type", 64'(rob_bus.commit_instr_type), cv ? 64'(h.itype) : 64'd0);
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    int    pos [NUM_CPL];
    bit    cv, exc, fire, alloc_ok;
    ment_t e;
    if (reset) begin
      mq.delete();
      m_tail  = 0;
      m_flush = 1'b0;
      return;
    end
    cv       = (mq.size() > 0) && mq[0].done;
    exc      = cv && (mq[0].exc != 3'd0);
    fire     = cv && rob_bus.commit_ready;
    alloc_ok = (mq.size() < DEPTH) && !rob_bus.stall && !exc;
    for (int p = 0; p < NUM_CPL; p++) begin
      pos[p] = -1;
      if (rob_bus.cpl_valid[p]) begin
        for (int k = 0; k < mq.size(); k++) begin
          if (mq[k].idx == int'(rob_bus.cpl_idx[p*IDX_W +: IDX_W]) && !mq[k].done) pos[p] = k;
        end
      end
    end
    for (int p = 0; p < NUM_CPL; p++) begin
      if (pos[p] >= 0) begin
        mq[pos[p]].value = rob_bus.cpl_value[p*XLEN +: XLEN];
        mq[pos[p]].exc   = rob_bus.cpl_exception[p*3 +: 3];
      end
    end
    for (int p = 0; p < NUM_CPL; p++) begin
      if (pos[p] >= 0) mq[pos[p]].done = 1'b1;
    end
    m_flush = 1'b0;
    if (fire) begin
      if (exc) begin
        mq.delete();
        m_tail  = 0;
        m_flush = 1'b1;
      end else begin
        void'(mq.pop_front());
      end
    end
    if (rob_bus.alloc_valid && alloc_ok) begin
      e.idx   = m_tail;
      e.pc    = rob_bus.alloc_pc;
      e.miss  = rob_bus.alloc_addr_miss;
      e.value = 32'd0;
      e.rd    = rob_bus.alloc_rd;
      e.itype = rob_bus.alloc_instr_type;
      e.exc   = 3'd0;
      e.done  = 1'b0;
      mq.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic tick();
    #1;
    compare_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_alloc(input bit v, input logic [31:0] pc, input logic [31:0] miss,
                           input logic [4:0] rd, input logic [2:0] it);
    rob_bus.alloc_valid      = v;
    rob_bus.alloc_pc         = pc;
    rob_bus.alloc_addr_miss  = miss;
    rob_bus.alloc_rd         = rd;
    rob_bus.alloc_instr_type = it;
  endtask

  task automatic set_cpl(input int p, input bit v, input logic [IDX_W-1:0] idx,
                         input logic [31:0] val, input logic [2:0] exc);
    rob_bus.cpl_valid[p]              = v;
    rob_bus.cpl_idx[p*IDX_W +: IDX_W] = idx;
    rob_bus.cpl_value[p*XLEN +: XLEN] = val;
    rob_bus.cpl_exception[p*3 +: 3]   = exc;
  endtask

  task automatic clr_cpl();
    for (int p = 0; p < NUM_CPL; p++) set_cpl(p, 1'b0, '0, 32'd0, 3'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                = 1'b1;
    rob_bus.stall        = 1'b0;
    rob_bus.commit_ready = 1'b1;
    set_alloc(1'b0, 32'd0, 32'd0, 5'd0, 3'd0);
    clr_cpl();
    repeat (2) @(posedge clk);
    model_step();
    @(negedge clk);
    reset = 1'b0;

    // Reset state.
    #1;
    chk("rst_empty", 64'(rob_bus.empty), 64'd1);
    chk("rst_count", 64'(rob_bus.count), 64'd0);
    chk("rst_ready", 64'(rob_bus.alloc_ready), 64'd1);
    chk("rst_cvalid", 64'(rob_bus.commit_valid), 64'd0);
    chk("rst_cpc", 64'(rob_bus.commit_pc), 64'd0);
    chk("rst_flush", 64'(rob_bus.flush), 64'd0);

    // Fill to full, then try an 11th allocation.
    for (int k = 0; k < DEPTH; k++) begin
      set_alloc(1'b1, 32'h100 + 32'(4 * k), 32'd0, 5'(k), 3'(k % 5));
      tick();
    end
    set_alloc(1'b1, 32'h200, 32'd0, 5'd31, 3'd0);
    #1;
    chk("fill_full", 64'(rob_bus.full), 64'd1);
    chk("fill_ready", 64'(rob_bus.alloc_ready), 64'd0);
    chk("fill_count", 64'(rob_bus.count), 64'd10);
    tick();
    set_alloc(1'b0, 32'd0, 32'd0, 5'd0, 3'd0);
    chk("drop_count", 64'(rob_bus.count), 64'd10);
    chk("drop_tail", 64'(rob_bus.alloc_idx), 64'd0);

    // Out-of-order completion, in-order commit.
    set_cpl(0, 1'b1, 4'd2, 32'hC, 3'd0); tick();
    chk("ooo_wait2", 64'(rob_bus.commit_valid), 64'd0);
    set_cpl(0, 1'b1, 4'd1, 32'hB, 3'd0); tick();
    chk("ooo_wait1", 64'(rob_bus.commit_valid), 64'd0);
    set_cpl(0, 1'b1, 4'd0, 32'hA, 3'd0); tick();
    clr_cpl();
    chk("ooo_idx0", 64'(rob_bus.commit_idx), 64'd0);
    chk("ooo_val0", 64'(rob_bus.commit_value), 64'hA);
    chk("ooo_pc0", 64'(rob_bus.commit_pc), 64'h100);
    tick();
    chk("ooo_idx1", 64'(rob_bus.commit_idx), 64'd1);
    chk("ooo_val1", 64'(rob_bus.commit_value), 64'hB);
    tick();
    chk("ooo_idx2", 64'(rob_bus.commit_idx), 64'd2);
    chk("ooo_val2", 64'(rob_bus.commit_value), 64'hC);
    tick();
    chk("ooo_after", 64'(rob_bus.commit_valid), 64'd0);
    chk("ooo_count", 64'(rob_bus.count), 64'd7);

    // Dual-port completion, distinct and colliding indices.
    rob_bus.commit_ready = 1'b0;
    set_cpl(0, 1'b1, 4'd3, 32'h33, 3'd0);
    set_cpl(1, 1'b1, 4'd4, 32'h44, 3'd0);
    tick();
    set_cpl(0, 1'b1, 4'd5, 32'd1, 3'd0);
    set_cpl(1, 1'b1, 4'd5, 32'd2, 3'd0);
    chk("dual_idx3", 64'(rob_bus.commit_idx), 64'd3);
    chk("dual_val3", 64'(rob_bus.commit_value), 64'h33);
    tick();
    clr_cpl();
    rob_bus.commit_ready = 1'b1;
    tick();
    chk("dual_val4", 64'(rob_bus.commit_value), 64'h44);
    tick();
    rob_bus.commit_ready = 1'b0;
    chk("coll_idx5", 64'(rob_bus.commit_idx), 64'd5);
    chk("coll_val5", 64'(rob_bus.commit_value), 64'd2);

    // Backpressure: head held for three cycles.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_valid", 64'(rob_bus.commit_valid), 64'd1);
      chk("bp_value", 64'(rob_bus.commit_value), 64'd2);
      chk("bp_count", 64'(rob_bus.count), 64'd5);
    end
    rob_bus.commit_ready = 1'b1;
    set_alloc(1'b1, 32'h500, 32'd0, 5'd7, 3'd1);
    tick();
    set_alloc(1'b0, 32'd0, 32'd0, 5'd0, 3'd0);
    chk("bp_swap_count", 64'(rob_bus.count), 64'd5);
    chk("bp_swap_tail", 64'(rob_bus.alloc_idx), 64'd1);
    chk("bp_swap_cv", 64'(rob_bus.commit_valid), 64'd0);

    // Exception flush from a fresh reset.
    reset = 1'b1; tick(); reset = 1'b0;
    chk("exc_rst_empty", 64'(rob_bus.empty), 64'd1);
    rob_bus.commit_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_alloc(1'b1, 32'h300 + 32'(4 * k), (k == 0) ? 32'hDEAD : 32'(k), 5'(k + 1), 3'd2);
      tick();
    end
    set_alloc(1'b0, 32'd0, 32'd0, 5'd0, 3'd0);
    set_cpl(0, 1'b1, 4'd0, 32'h77, 3'd2);
    tick();
    clr_cpl();
    set_alloc(1'b1, 32'h999, 32'd0, 5'd9, 3'd0);
    #1;
    chk("exc_cv", 64'(rob_bus.commit_valid), 64'd1);
    chk("exc_pc", 64'(rob_bus.commit_pc), 64'h300);
    chk("exc_miss", 64'(rob_bus.commit_addr_miss), 64'hDEAD);
    chk("exc_code", 64'(rob_bus.commit_exception), 64'd2);
    chk("exc_ready", 64'(rob_bus.alloc_ready), 64'd0);
    tick();
    set_alloc(1'b0, 32'd0, 32'd0, 5'd0, 3'd0);
    chk("exc_held_count", 64'(rob_bus.count), 64'd4);
    rob_bus.commit_ready = 1'b1;
    tick();
    chk("flush_pulse", 64'(rob_bus.flush), 64'd1);
    chk("flush_empty", 64'(rob_bus.empty), 64'd1);
    chk("flush_tail", 64'(rob_bus.alloc_idx), 64'd0);
    set_cpl(0, 1'b1, 4'd2, 32'h55, 3'd0);
    tick();
    clr_cpl();
    chk("flush_once", 64'(rob_bus.flush), 64'd0);
    chk("late_cpl_count", 64'(rob_bus.count), 64'd0);
    chk("late_cpl_cv", 64'(rob_bus.commit_valid), 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset                = ($urandom_range(0, 399) == 0);
      rob_bus.stall        = ($urandom_range(0, 5) == 0);
      rob_bus.commit_ready = ($urandom_range(0, 3) != 0);
      set_alloc($urandom_range(0, 2) != 0, $urandom, $urandom, 5'($urandom_range(0, 31)),
                3'($urandom_range(0, 4)));
      for (int p = 0; p < NUM_CPL; p++) begin
        logic [IDX_W-1:0] ci;
        if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
          ci = IDX_W'(mq[$urandom_range(0, mq.size() - 1)].idx);
        end else begin
          ci = IDX_W'($urandom_range(0, 15));
        end
        set_cpl(p, $urandom_range(0, 1) != 0, ci, $urandom,
                ($urandom_range(0, 31) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
      end
      if (rob_bus.cpl_valid[0] && rob_bus.cpl_valid[1] &&
          rob_bus.cpl_idx[0 +: IDX_W] == rob_bus.cpl_idx[IDX_W +: IDX_W]) begin
        rob_bus.cpl_valid[0] = 1'b0;
      end
      tick();
    end
    reset = 1'b0;
    clr_cpl();
    set_alloc(1'b0, 32'd0, 32'd0, 5'd0, 3'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
